// File: rtl/fib_bcd_converter.sv
// Sequential binary-to-packed-BCD converter (double-dabble, one bit per cycle) with valid/ready on both sides.
// Define FIB_BCD_SEG7_EN to add the registered seven-segment output seg_out.
module fib_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  input  logic                  bcd_ready
`ifdef FIB_BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  logic [WIDTH-1:0] bin_r;
  logic [BW-1:0]   acc_r;
  logic [CW-1:0]   count_r;
  logic [BW-1:0]   acc_next_s;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] acc, input logic msb);
    logic [BW-1:0] a;
    a = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        a[4*i +: 4] = a[4*i +: 4];
      end
    end
    return (a << 1) | BW'(msb);
  endfunction

`ifdef FIB_BCD_SEG7_EN
  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7*DIGITS-1:0] seg7_all(input logic [BW-1:0] bcd);
    logic [7*DIGITS-1:0] s;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s[7*i +: 7] = seg7_digit(bcd[4*i +: 4]);
    end
    return s;
  endfunction
`endif

  assign acc_next_s = dabble_step(acc_r, bin_r[WIDTH-1]);
  assign bin_ready  = (state_r == IDLE);

  // Conversion FSM with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      bin_r     <= '0;
      acc_r     <= '0;
      count_r   <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
`ifdef FIB_BCD_SEG7_EN
      seg_out   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bin_valid) begin
            bin_r   <= bin_in;
            acc_r   <= '0;
            count_r <= '0;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          acc_r   <= acc_next_s;
          bin_r   <= {bin_r[WIDTH-2:0], 1'b0};
          count_r <= count_r + CW'(1);
          if (count_r == LAST_COUNT) begin
            bcd_out   <= acc_next_s;
            bcd_valid <= 1'b1;
`ifdef FIB_BCD_SEG7_EN
            seg_out   <= seg7_all(acc_next_s);
`endif
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (bcd_ready) begin
            bcd_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          bcd_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter: vector table, handshake corner cases, random conversions.
// Seven-segment checks compile in when FIB_BCD_SEG7_EN is defined.
module tb_fib_bcd_converter;

  localparam int W = 16;
  localparam int D = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     bin_in = '0;
  logic             bin_valid = 1'b0;
  logic             bin_ready;
  logic [4*D-1:0]   bcd_out;
  logic             bcd_valid;
  logic             bcd_ready = 1'b0;
`ifdef FIB_BCD_SEG7_EN
  logic [7*D-1:0]   seg_out;
`endif

  int n_checks = 0;
  int n_err = 0;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic [W-1:0]   bin;
    logic [4*D-1:0] bcd;
  } vec_t;

  vec_t vecs [8];

  fib_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready)
`ifdef FIB_BCD_SEG7_EN
    ,
    .seg_out   (seg_out)
`endif
  );

  always #5 clk = ~clk;

  // Decimal digits by plain arithmetic.
  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned n;
    r = '0;
    n = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] to_seg(input int unsigned v);
    logic [7*D-1:0] s;
    int unsigned n;
    s = '0;
    n = v;
    for (int i = 0; i < D; i++) begin
      s[7*i +: 7] = seg_tab[n % 10];
      n = n / 10;
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: accept, latency, optional consumer stall, handshake.
  task automatic run_conv(input logic [W-1:0] v, input int hold, input string nm);
    int lat;
    logic [4*D-1:0] exp_bcd;
    exp_bcd = to_bcd(32'(v));
    lat = 0;
    while (!bin_ready && lat < 50) begin
      tick();
      lat++;
    end
    check({nm, " bin_ready"}, 64'(bin_ready), 64'd1);
    bin_in = v;
    bin_valid = 1'b1;
    tick();
    lat = 0;
    while (!bcd_valid && lat < 40) begin
      bin_valid = 1'($urandom);
      bin_in = W'($urandom);
      tick();
      lat++;
    end
    bin_valid = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'd16);
    check({nm, " bcd_out"}, 64'(bcd_out), 64'(exp_bcd));
`ifdef FIB_BCD_SEG7_EN
    check({nm, " seg_out"}, 64'(seg_out), 64'(to_seg(32'(v))));
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      check({nm, " hold"}, 64'({bcd_valid, bin_ready, bcd_out}), 64'({1'b1, 1'b0, exp_bcd}));
    end
    bcd_ready = 1'b1;
    tick();
    bcd_ready = 1'b0;
    check({nm, " release"}, 64'({bcd_valid, bin_ready, bcd_out}), 64'({1'b0, 1'b1, exp_bcd}));
  endtask

  initial begin
    logic [4*D-1:0] q [$];
    logic [4*D-1:0] held;
    int cyc, last, results;
    logic acc_flag;

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd6765,  20'h06765};
    vecs[2] = '{16'hFFFF,  20'h65535};
    vecs[3] = '{16'd144,   20'h00144};
    vecs[4] = '{16'd9999,  20'h09999};
    vecs[5] = '{16'd10000, 20'h10000};
    vecs[6] = '{16'd1,     20'h00001};
    vecs[7] = '{16'd1234,  20'h01234};

    // Reset state
    repeat (2) tick();
    check("reset bcd_valid", 64'(bcd_valid), 64'd0);
    check("reset bcd_out", 64'(bcd_out), 64'd0);
`ifdef FIB_BCD_SEG7_EN
    check("reset seg_out", 64'(seg_out), 64'd0);
`endif
    reset = 1'b0;
    tick();
    check("post-reset bin_ready", 64'(bin_ready), 64'd1);

    // Vector table (model cross-checks the hand-written expectations)
    for (int i = 0; i < 8; i++) begin
      check("table model", 64'(to_bcd(32'(vecs[i].bin))), 64'(vecs[i].bcd));
      run_conv(vecs[i].bin, 0, $sformatf("vec%0d", i));
    end

`ifdef FIB_BCD_SEG7_EN
    check("seg 1234", 64'(seg_out), 64'({7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66}));
`endif

    // Consumer stall with new bin_valid offered during DONE
    bin_in = 16'd4181;
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    cyc = 0;
    while (!bcd_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    held = bcd_out;
    check("stall result", 64'(held), 64'h04181);
    for (int h = 0; h < 5; h++) begin
      bin_valid = 1'b1;
      bin_in = 16'd777;
      tick();
      check("stall hold", 64'({bcd_valid, bin_ready, bcd_out}), 64'({1'b1, 1'b0, held}));
    end
    bin_valid = 1'b0;
    bcd_ready = 1'b1;
    tick();
    bcd_ready = 1'b0;
    check("stall release", 64'({bcd_valid, bin_ready}), 64'({1'b0, 1'b1}));
    repeat (3) tick();
    check("stall no accept", 64'({bcd_valid, bin_ready, bcd_out}), 64'({1'b0, 1'b1, held}));

    // Reset in the middle of a conversion
    run_conv(16'd12345, 1, "pre-reset");
    bin_in = 16'd999;
    bin_valid = 1'b1;
    tick();
    bin_valid = 1'b0;
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    check("mid reset outputs", 64'({bcd_valid, bcd_out}), 64'd0);
    check("mid reset bin_ready", 64'(bin_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    run_conv(16'd144, 0, "after reset");

    // Level-held bin_valid, alternating terms, consumer always ready
    bin_in = 16'd55;
    bin_valid = 1'b1;
    bcd_ready = 1'b1;
    cyc = 0;
    last = -1;
    results = 0;
    while (results < 6 && cyc < 300) begin
      acc_flag = bin_ready;
      if (acc_flag) q.push_back(to_bcd(32'(bin_in)));
      tick();
      cyc++;
      if (acc_flag) bin_in = (bin_in == 16'd55) ? 16'd89 : 16'd55;
      if (bcd_valid) begin
        if (q.size() == 0) check("stream extra result", 64'(bcd_out), 64'h0)
        ;
        if (q.size() != 0) check("stream value", 64'(bcd_out), 64'(q.pop_front()));
        if (last >= 0) check("stream spacing", 64'(cyc - last), 64'd18);
        last = cyc;
        results++;
      end
    end
    bin_valid = 1'b0;
    check("stream count", 64'(results), 64'd6);
    tick();
    bcd_ready = 1'b0;
    check("stream idle", 64'({bcd_valid, bin_ready}), 64'({1'b0, 1'b1}));

    // Random terms and random consumer stalls
    for (int k = 0; k < 25; k++) begin
      run_conv(W'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
